// File: rtl/rom_mux_pkg.sv
// Shared constants and reset-threshold helper for the ROM address selector family.
package rom_mux_pkg;
  localparam int MAX_NCH = 8;
  localparam int SEL_W   = 3;

  // Threshold k resets to (k+1)*step, clamped to the largest CW-bit value.
  function automatic logic [63:0] rst_thr(input int k, input int step, input int cw);
    logic [63:0] v, mx;
    v  = 64'(k + 1) * 64'(step);
    mx = (64'd1 << cw) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction
endpackage

// File: rtl/rom_region_enc.sv
// Region encoder: sel is the number of thresholds strictly exceeded by cur_idx.
module rom_region_enc
  import rom_mux_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CW  = 16
) (
  input  logic [CW-1:0]           cur_idx_i,
  input  logic [NCH-2:0][CW-1:0]  thr_i,
  output logic [SEL_W-1:0]        sel_o
);
  // A count rather than a priority search keeps unordered thresholds well defined.
  always_comb begin
    sel_o = '0;
    for (int k = 0; k < NCH - 1; k++)
      if (cur_idx_i > thr_i[k]) sel_o = sel_o + SEL_W'(1);
  end
endmodule

// File: rtl/rom_addr_mux_n.sv
// NCH-source ROM address selector for the sprite path; frame-committed thresholds,
// one registered lookup per pixel strobe.
module rom_addr_mux_n
  import rom_mux_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int AW       = 16,
  parameter int CW       = 16,
  parameter int THR_STEP = 600
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                pix_en,
  input  logic [NCH*AW-1:0]   ch_addr,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_idx,
  input  logic [CW-1:0]       cfg_thr,
  output logic [AW-1:0]       rom_addr,
  output logic [SEL_W-1:0]    rom_sel,
  output logic                rom_addr_vld,
  output logic [CW-1:0]       pix_idx
);
  typedef logic [NCH-2:0][CW-1:0] thr_t;

  function automatic thr_t thr_rst_vals();
    thr_t        r;
    logic [63:0] v;
    for (int k = 0; k < NCH - 1; k++) begin
      v    = rst_thr(k, THR_STEP, CW);
      r[k] = v[CW-1:0];
    end
    return r;
  endfunction

  localparam thr_t          THR_RST = thr_rst_vals();
  localparam logic [CW-1:0] IDX_MAX = '1;

  thr_t             shadow_q, shadow_d, act_q, act_d;
  logic [CW-1:0]    pix_idx_q, pix_idx_d, cur_idx;
  logic [SEL_W-1:0] sel, rom_sel_q, rom_sel_d;
  logic [AW-1:0]    sel_addr, rom_addr_q, rom_addr_d;
  logic             vld_q, vld_d;

  // Commit goes through shadow_d so a write on the frame_start cycle lands at once.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we)
      for (int k = 0; k < NCH - 1; k++)
        if (cfg_idx == SEL_W'(k)) shadow_d[k] = cfg_thr;
    act_d = frame_start ? shadow_d : act_q;
  end

  assign cur_idx = frame_start ? '0 : pix_idx_q;

  always_comb begin
    pix_idx_d = pix_idx_q;
    if (pix_en)
      pix_idx_d = (cur_idx == IDX_MAX) ? IDX_MAX : cur_idx + CW'(1);
    else if (frame_start)
      pix_idx_d = '0;
  end

  rom_region_enc #(.NCH(NCH), .CW(CW)) u_enc (
    .cur_idx_i (cur_idx),
    .thr_i     (act_d),
    .sel_o     (sel)
  );

  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < NCH; k++)
      if (sel == SEL_W'(k)) sel_addr = ch_addr[k*AW +: AW];
  end

  always_comb begin
    rom_addr_d = pix_en ? sel_addr : rom_addr_q;
    rom_sel_d  = pix_en ? sel : rom_sel_q;
    vld_d      = pix_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= THR_RST;
      act_q      <= THR_RST;
      pix_idx_q  <= '0;
      rom_addr_q <= '0;
      rom_sel_q  <= '0;
      vld_q      <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      act_q      <= act_d;
      pix_idx_q  <= pix_idx_d;
      rom_addr_q <= rom_addr_d;
      rom_sel_q  <= rom_sel_d;
      vld_q      <= vld_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign rom_sel      = rom_sel_q;
  assign rom_addr_vld = vld_q;
  assign pix_idx      = pix_idx_q;
endmodule
